// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-outstanding word load/store responder over a small
//            big-endian byte store, with a parameterised read latency and
//            a misaligned-request error response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int RD_LAT = 2,   // load latency in cycles, 1..7
   parameter int DEPTH  = 32   // byte count; index arithmetic wraps at 5 bits
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [4:0]  i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [2:0] C_CNT_INIT = 3'(RD_LAT - 1);

   logic [1:0]  r_state;
   logic [2:0]  r_cnt;
   logic [4:0]  r_addr;
   logic [7:0]  r_mem [DEPTH];
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic [1:0]  w_next_state;
   logic [2:0]  w_cnt_next;
   logic        w_accept;
   logic        w_aligned;
   logic        w_store;
   logic        w_load;
   logic [4:0]  w_rd_addr;
   logic [31:0] w_rd_word;
   logic        w_ready_nxt;
   logic        w_valid_nxt;
   logic        w_err_nxt;
   logic [31:0] w_rdata_nxt;

   // r_req_ready is only ever high in IDLE, so it alone qualifies acceptance
   assign w_accept  = i_req_valid && r_req_ready;
   assign w_aligned = (i_req_addr[1:0] == 2'b00);
   assign w_store   = w_accept && w_aligned && i_req_write;
   assign w_load    = w_accept && w_aligned && !i_req_write;

   // With RD_LAT=1 the word is read straight off the request address
   assign w_rd_addr = (r_state == S_IDLE) ? i_req_addr : r_addr;
   assign w_rd_word = {r_mem[w_rd_addr],
                       r_mem[w_rd_addr + 5'd1],
                       r_mem[w_rd_addr + 5'd2],
                       r_mem[w_rd_addr + 5'd3]};

   // State register, latency counter and latched load address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_addr  <= 5'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         if (w_load) begin
            r_addr <= i_req_addr;
         end
      end
   end

   // Next-state and counter decode
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_load) begin
                  w_cnt_next   = C_CNT_INIT;
                  w_next_state = (RD_LAT == 1) ? S_RESP : S_WAIT;
               end else begin
                  w_next_state = S_RESP;
               end
            end
         end
         S_WAIT: begin
            w_cnt_next = r_cnt - 3'd1;
            if (r_cnt <= 3'd1) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            if (i_resp_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; response fields are captured on
   // entry to RESP and then held until the handshake
   always_comb begin
      w_ready_nxt = (w_next_state == S_IDLE);
      w_valid_nxt = (w_next_state == S_RESP);
      w_err_nxt   = r_resp_err;
      w_rdata_nxt = r_resp_rdata;
      if (w_next_state == S_RESP && r_state != S_RESP) begin
         w_err_nxt   = (r_state == S_IDLE) && !w_aligned;
         w_rdata_nxt = ((r_state == S_WAIT) || w_load) ? w_rd_word : 32'd0;
      end else if (w_next_state != S_RESP) begin
         w_err_nxt   = 1'b0;
         w_rdata_nxt = 32'd0;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         r_req_ready  <= w_ready_nxt;
         r_resp_valid <= w_valid_nxt;
         r_resp_rdata <= w_rdata_nxt;
         r_resp_err   <= w_err_nxt;
      end
   end

   // Byte store: aligned stores write all four bytes on the acceptance edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 8'd0;
         end
      end else if (w_store) begin
         r_mem[i_req_addr]        <= i_req_wdata[31:24];
         r_mem[i_req_addr + 5'd1] <= i_req_wdata[23:16];
         r_mem[i_req_addr + 5'd2] <= i_req_wdata[15:8];
         r_mem[i_req_addr + 5'd3] <= i_req_wdata[7:0];
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire
